// File: rtl/vend_pkg.sv
// Shared types and default parameters for the vending transaction controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package vend_pkg;

  localparam int CURRENCY_WIDTH_DEF = 7;
  localparam int NUM_ITEMS_DEF      = 4;
  localparam int ITEM_W_DEF         = 2;
  localparam int STOCK_WIDTH_DEF    = 4;
  localparam int INIT_STOCK_DEF     = 5;

  // Item 0 sits in the LSBs: item0=10, item1=15, item2=20, item3=25.
  localparam logic [NUM_ITEMS_DEF*CURRENCY_WIDTH_DEF-1:0] ITEM_PRICES_DEF =
    {7'd25, 7'd20, 7'd15, 7'd10};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_CLEAR,
    ST_DONE
  } state_e;

  typedef enum logic {
    MODE_VEND,
    MODE_REFUND
  } mode_e;

endpackage

// File: rtl/vend_stock.sv
// Per-item saturating stock counters with decrement and restock ports.
// Latency: stock and stock_empty reflect an update on the clock edge that applies it.
// Backpressure: none; decrement and restock are accepted every cycle, restock saturates.
module vend_stock
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS   = NUM_ITEMS_DEF,
  parameter int ITEM_W      = ITEM_W_DEF,
  parameter int STOCK_WIDTH = STOCK_WIDTH_DEF,
  parameter int INIT_STOCK  = INIT_STOCK_DEF
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             dec_vld,
  input  logic [ITEM_W-1:0]                dec_item,
  input  logic                             restock_vld,
  input  logic [ITEM_W-1:0]                restock_item,
  input  logic [STOCK_WIDTH-1:0]           restock_qty,
  output logic [NUM_ITEMS*STOCK_WIDTH-1:0] stock_lvl,
  output logic [NUM_ITEMS-1:0]             stock_empty
);

  localparam logic [STOCK_WIDTH:0]   STOCK_MAX  = {1'b0, {STOCK_WIDTH{1'b1}}};
  localparam logic [STOCK_WIDTH-1:0] STOCK_INIT = STOCK_WIDTH'(INIT_STOCK);
  localparam logic [STOCK_WIDTH:0]   ONE        = {{STOCK_WIDTH{1'b0}}, 1'b1};

  logic [STOCK_WIDTH-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_WIDTH-1:0] stock_d [NUM_ITEMS];
  logic [STOCK_WIDTH:0]   sum     [NUM_ITEMS];
  logic [NUM_ITEMS-1:0]   empty_q;
  logic [NUM_ITEMS-1:0]   empty_d;

  // Next stock: decrement first, then add restock in one extra bit, then clamp to max.
  always_comb begin
    empty_d = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sum[i] = {1'b0, stock_q[i]};
      if (dec_vld && (dec_item == ITEM_W'(i)) && (stock_q[i] != '0)) begin
        sum[i] = sum[i] - ONE;
      end
      if (restock_vld && (restock_item == ITEM_W'(i))) begin
        sum[i] = sum[i] + {1'b0, restock_qty};
      end
      stock_d[i] = (sum[i] > STOCK_MAX) ? STOCK_MAX[STOCK_WIDTH-1:0] : sum[i][STOCK_WIDTH-1:0];
      empty_d[i] = (stock_d[i] == '0);
    end
  end

  // Stock counters and sold-out flags; reset restores the initial stock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_INIT;
      end
      empty_q <= {NUM_ITEMS{INIT_STOCK == 0}};
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= stock_d[i];
      end
      empty_q <= empty_d;
    end
  end

  // Flatten counters so the controller can pick the selected item's level.
  always_comb begin
    stock_lvl = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_lvl[i*STOCK_WIDTH +: STOCK_WIDTH] = stock_q[i];
    end
  end

  assign stock_empty = empty_q;

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: select/cancel handling, price and stock check, credit clear, change.
// Latency: select at T -> error at T+2 or dispense_valid at T+2, vend/change one cycle after credit clears.
// Backpressure: dispense_valid is held until currency_avail falls; no timeout.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CURRENCY_WIDTH = CURRENCY_WIDTH_DEF,
  parameter int NUM_ITEMS      = NUM_ITEMS_DEF,
  parameter int ITEM_W         = ITEM_W_DEF,
  parameter int STOCK_WIDTH    = STOCK_WIDTH_DEF,
  parameter logic [NUM_ITEMS*CURRENCY_WIDTH-1:0] ITEM_PRICES = ITEM_PRICES_DEF,
  parameter int INIT_STOCK     = INIT_STOCK_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CURRENCY_WIDTH-1:0] total_currency,
  input  logic                      currency_avail,
  input  logic                      select_valid,
  input  logic [ITEM_W-1:0]         select_item,
  input  logic                      cancel,
  input  logic                      restock_valid,
  input  logic [ITEM_W-1:0]         restock_item,
  input  logic [STOCK_WIDTH-1:0]    restock_qty,
  output logic                      dispense_valid,
  output logic                      vend_valid,
  output logic [ITEM_W-1:0]         vend_item,
  output logic                      change_valid,
  output logic [CURRENCY_WIDTH-1:0] change_value,
  output logic                      err_funds,
  output logic                      err_stock,
  output logic [NUM_ITEMS-1:0]      stock_empty,
  output logic                      busy
);

  state_e                    state_q, state_d;
  mode_e                     mode_q, mode_d;
  logic [ITEM_W-1:0]         item_q, item_d;
  logic [CURRENCY_WIDTH-1:0] total_q, total_d;
  logic                      dispense_q, dispense_d;
  logic                      vend_vld_q, vend_vld_d;
  logic [ITEM_W-1:0]         vend_item_q, vend_item_d;
  logic                      change_vld_q, change_vld_d;
  logic [CURRENCY_WIDTH-1:0] change_val_q, change_val_d;
  logic                      err_funds_q, err_funds_d;
  logic                      err_stock_q, err_stock_d;
  logic                      busy_q, busy_d;

  logic                          dec_vld;
  logic [NUM_ITEMS*STOCK_WIDTH-1:0] stock_lvl;
  logic [STOCK_WIDTH-1:0]        item_stock;
  logic [CURRENCY_WIDTH-1:0]     price_sel;

  vend_stock #(
    .NUM_ITEMS  (NUM_ITEMS),
    .ITEM_W     (ITEM_W),
    .STOCK_WIDTH(STOCK_WIDTH),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk         (clk),
    .rstn        (rstn),
    .dec_vld     (dec_vld),
    .dec_item    (item_q),
    .restock_vld (restock_valid),
    .restock_item(restock_item),
    .restock_qty (restock_qty),
    .stock_lvl   (stock_lvl),
    .stock_empty (stock_empty)
  );

  assign price_sel  = ITEM_PRICES[item_q*CURRENCY_WIDTH +: CURRENCY_WIDTH];
  assign item_stock = stock_lvl[item_q*STOCK_WIDTH +: STOCK_WIDTH];

  // Transaction FSM: next state, latched transaction fields and registered output values.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    item_d       = item_q;
    total_d      = total_q;
    dec_vld      = 1'b0;
    vend_vld_d   = 1'b0;
    vend_item_d  = vend_item_q;
    change_vld_d = 1'b0;
    change_val_d = change_val_q;
    err_funds_d  = 1'b0;
    err_stock_d  = 1'b0;
    if (currency_avail) begin
      total_d = total_currency;
    end
    case (state_q)
      ST_IDLE: begin
        if (currency_avail) state_d = ST_COLLECT;
        if (select_valid)   err_funds_d = 1'b1;
      end
      ST_COLLECT: begin
        if (cancel) begin
          mode_d  = MODE_REFUND;
          state_d = ST_CLEAR;
        end else if (select_valid) begin
          item_d  = select_item;
          state_d = ST_CHECK;
        end else if (!currency_avail) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (item_stock == '0) begin
          err_stock_d = 1'b1;
          state_d     = ST_COLLECT;
        end else if (total_currency < price_sel) begin
          err_funds_d = 1'b1;
          state_d     = ST_COLLECT;
        end else begin
          dec_vld = 1'b1;
          mode_d  = MODE_VEND;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // Credit keeps tracking late coins until the accumulator confirms the clear.
        if (!currency_avail) begin
          state_d      = ST_DONE;
          change_vld_d = 1'b1;
          if (mode_q == MODE_VEND) begin
            vend_vld_d   = 1'b1;
            vend_item_d  = item_q;
            change_val_d = total_q - price_sel;
          end else begin
            change_val_d = total_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    dispense_d = (state_d == ST_CLEAR);
    busy_d     = (state_d == ST_CHECK) || (state_d == ST_CLEAR) || (state_d == ST_DONE);
  end

  // State and output registers; reset aborts any transaction without reporting it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_VEND;
      item_q       <= '0;
      total_q      <= '0;
      dispense_q   <= 1'b0;
      vend_vld_q   <= 1'b0;
      vend_item_q  <= '0;
      change_vld_q <= 1'b0;
      change_val_q <= '0;
      err_funds_q  <= 1'b0;
      err_stock_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      item_q       <= item_d;
      total_q      <= total_d;
      dispense_q   <= dispense_d;
      vend_vld_q   <= vend_vld_d;
      vend_item_q  <= vend_item_d;
      change_vld_q <= change_vld_d;
      change_val_q <= change_val_d;
      err_funds_q  <= err_funds_d;
      err_stock_q  <= err_stock_d;
      busy_q       <= busy_d;
    end
  end

  assign dispense_valid = dispense_q;
  assign vend_valid     = vend_vld_q;
  assign vend_item      = vend_item_q;
  assign change_valid   = change_vld_q;
  assign change_value   = change_val_q;
  assign err_funds      = err_funds_q;
  assign err_stock      = err_stock_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: per-cycle vector table plus directed multi-cycle sequences.
// Latency: expected outputs are sampled 1 time unit after each rising edge.
// Backpressure: the bench acts as the accumulator, dropping currency_avail after dispense_valid.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] total_currency;
  logic       currency_avail;
  logic       select_valid;
  logic [1:0] select_item;
  logic       cancel;
  logic       restock_valid;
  logic [1:0] restock_item;
  logic [3:0] restock_qty;
  logic       dispense_valid;
  logic       vend_valid;
  logic [1:0] vend_item;
  logic       change_valid;
  logic [6:0] change_value;
  logic       err_funds;
  logic       err_stock;
  logic [3:0] stock_empty;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  vend_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .total_currency(total_currency),
    .currency_avail(currency_avail),
    .select_valid  (select_valid),
    .select_item   (select_item),
    .cancel        (cancel),
    .restock_valid (restock_valid),
    .restock_item  (restock_item),
    .restock_qty   (restock_qty),
    .dispense_valid(dispense_valid),
    .vend_valid    (vend_valid),
    .vend_item     (vend_item),
    .change_valid  (change_valid),
    .change_value  (change_value),
    .err_funds     (err_funds),
    .err_stock     (err_stock),
    .stock_empty   (stock_empty),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] tot;
    logic       av;
    logic       sel;
    logic [1:0] it;
    logic       can;
    logic       e_disp;
    logic       e_vend;
    logic [1:0] e_item;
    logic       e_chg;
    logic [6:0] e_val;
    logic       e_ef;
    logic       e_es;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int tot, input int av, input int sel, input int it, input int can,
                     input int disp, input int vend, input int item, input int chg, input int val,
                     input int ef, input int es, input int bsy);
    vec_t v;
    v.tot = 7'(tot); v.av = 1'(av); v.sel = 1'(sel); v.it = 2'(it); v.can = 1'(can);
    v.e_disp = 1'(disp); v.e_vend = 1'(vend); v.e_item = 2'(item); v.e_chg = 1'(chg);
    v.e_val = 7'(val); v.e_ef = 1'(ef); v.e_es = 1'(es); v.e_busy = 1'(bsy);
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    total_currency = '0; currency_avail = 1'b0; select_valid = 1'b0; select_item = '0;
    cancel = 1'b0; restock_valid = 1'b0; restock_item = '0; restock_qty = '0;
  endtask

  // Full purchase with the bench acting as accumulator; returns when the vend pulse is seen.
  task automatic vend_once(input int item, input int amt, input string tag);
    bit got = 0;
    @(negedge clk); total_currency = 7'(amt); currency_avail = 1'b1;
    @(negedge clk); select_valid = 1'b1; select_item = 2'(item);
    @(negedge clk); select_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (vend_valid) begin
        got = 1;
        break;
      end
      if (dispense_valid) begin
        currency_avail = 1'b0; total_currency = '0;
      end
    end
    chk({tag, " vend seen"}, int'(got), 1);
    if (got) chk({tag, " vend_item"}, int'(vend_item), item);
    currency_avail = 1'b0; total_currency = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst dispense_valid", int'(dispense_valid), 0);
    chk("rst vend_valid",     int'(vend_valid), 0);
    chk("rst vend_item",      int'(vend_item), 0);
    chk("rst change_valid",   int'(change_valid), 0);
    chk("rst change_value",   int'(change_value), 0);
    chk("rst err_funds",      int'(err_funds), 0);
    chk("rst err_stock",      int'(err_stock), 0);
    chk("rst stock_empty",    int'(stock_empty), 0);
    chk("rst busy",           int'(busy), 0);
    rstn = 1'b1;

    //  tot av sel it can | disp vend item chg val ef es busy
    // exact payment: 10 then 5, select item1 (15), accumulator clears one cycle after dispense
    add(10,1,0,0,0, 0,0,0,0, 0,0,0,0);
    add(15,1,0,0,0, 0,0,0,0, 0,0,0,0);
    add(15,1,1,1,0, 0,0,0,0, 0,0,0,1);
    add(15,1,0,0,0, 1,0,0,0, 0,0,0,1);
    add(15,1,0,0,0, 1,0,0,0, 0,0,0,1);
    add( 0,0,0,0,0, 0,1,1,1, 0,0,0,1);
    add( 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    // overpay: 25 for item0 -> change 15
    add(25,1,0,0,0, 0,0,0,0, 0,0,0,0);
    add(25,1,1,0,0, 0,0,0,0, 0,0,0,1);
    add(25,1,0,0,0, 1,0,0,0, 0,0,0,1);
    add(25,1,0,0,0, 1,0,0,0, 0,0,0,1);
    add( 0,0,0,0,0, 0,1,0,1,15,0,0,1);
    add( 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    // overpay with a 5 arriving during CLEAR -> change 20
    add(25,1,0,0,0, 0,0,0,0, 0,0,0,0);
    add(25,1,1,0,0, 0,0,0,0, 0,0,0,1);
    add(25,1,0,0,0, 1,0,0,0, 0,0,0,1);
    add(30,1,0,0,0, 1,0,0,0, 0,0,0,1);
    add(30,1,0,0,0, 1,0,0,0, 0,0,0,1);
    add( 0,0,0,0,0, 0,1,0,1,20,0,0,1);
    add( 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    // insufficient funds for item3, then top up to 25 and buy it
    add(10,1,0,0,0, 0,0,0,0, 0,0,0,0);
    add(10,1,1,3,0, 0,0,0,0, 0,0,0,1);
    add(10,1,0,0,0, 0,0,0,0, 0,1,0,0);
    add(10,1,0,0,0, 0,0,0,0, 0,0,0,0);
    add(25,1,0,0,0, 0,0,0,0, 0,0,0,0);
    add(25,1,1,3,0, 0,0,0,0, 0,0,0,1);
    add(25,1,0,0,0, 1,0,0,0, 0,0,0,1);
    add(25,1,0,0,0, 1,0,0,0, 0,0,0,1);
    add( 0,0,0,0,0, 0,1,3,1, 0,0,0,1);
    add( 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    // cancel together with select: refund 20, no vend
    add(20,1,0,0,0, 0,0,0,0, 0,0,0,0);
    add(20,1,1,0,1, 1,0,0,0, 0,0,0,1);
    add(20,1,0,0,0, 1,0,0,0, 0,0,0,1);
    add( 0,0,0,0,0, 0,0,0,1,20,0,0,1);
    add( 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    // select with no credit in IDLE
    add( 0,0,1,0,0, 0,0,0,0, 0,1,0,0);
    add( 0,0,0,0,0, 0,0,0,0, 0,0,0,0);

    foreach (tbl[k]) begin
      @(negedge clk);
      total_currency = tbl[k].tot; currency_avail = tbl[k].av;
      select_valid = tbl[k].sel; select_item = tbl[k].it; cancel = tbl[k].can;
      @(posedge clk); #1;
      chk($sformatf("row%0d dispense_valid", k), int'(dispense_valid), int'(tbl[k].e_disp));
      chk($sformatf("row%0d vend_valid", k),     int'(vend_valid),     int'(tbl[k].e_vend));
      chk($sformatf("row%0d change_valid", k),   int'(change_valid),   int'(tbl[k].e_chg));
      chk($sformatf("row%0d err_funds", k),      int'(err_funds),      int'(tbl[k].e_ef));
      chk($sformatf("row%0d err_stock", k),      int'(err_stock),      int'(tbl[k].e_es));
      chk($sformatf("row%0d busy", k),           int'(busy),           int'(tbl[k].e_busy));
      if (tbl[k].e_vend) chk($sformatf("row%0d vend_item", k), int'(vend_item), int'(tbl[k].e_item));
      if (tbl[k].e_chg)  chk($sformatf("row%0d change_value", k), int'(change_value), int'(tbl[k].e_val));
    end
    idle_inputs();

    // item0 sold twice, item1 and item3 once, refund left stock untouched
    chk("stock0 after table", int'(dut.u_stock.stock_q[0]), 3);
    chk("stock1 after table", int'(dut.u_stock.stock_q[1]), 4);
    chk("stock2 after table", int'(dut.u_stock.stock_q[2]), 5);
    chk("stock3 after table", int'(dut.u_stock.stock_q[3]), 4);

    // sell out item2, then try once more
    for (int n = 0; n < 5; n++) vend_once(2, 20, $sformatf("item2 sale%0d", n));
    chk("stock_empty after sellout", int'(stock_empty), 4'b0100);
    @(negedge clk); total_currency = 7'd20; currency_avail = 1'b1;
    @(negedge clk); select_valid = 1'b1; select_item = 2'd2;
    @(negedge clk); select_valid = 1'b0;
    @(posedge clk); #1;
    chk("soldout err_stock", int'(err_stock), 1);
    chk("soldout err_funds", int'(err_funds), 0);
    chk("soldout dispense_valid", int'(dispense_valid), 0);
    @(negedge clk); currency_avail = 1'b0; total_currency = '0;
    repeat (2) @(negedge clk);

    // restock 3 clears the flag, restock 15 saturates
    restock_valid = 1'b1; restock_item = 2'd2; restock_qty = 4'd3;
    @(negedge clk); restock_valid = 1'b0;
    chk("restock3 stock_empty", int'(stock_empty), 0);
    chk("restock3 stock2", int'(dut.u_stock.stock_q[2]), 3);
    restock_valid = 1'b1; restock_qty = 4'd15;
    @(negedge clk); restock_valid = 1'b0;
    chk("restock15 saturates", int'(dut.u_stock.stock_q[2]), 15);

    // restock item1 by 5 during the CHECK cycle that decrements it: 4-1+5 = 8
    @(negedge clk); total_currency = 7'd15; currency_avail = 1'b1;
    @(negedge clk); select_valid = 1'b1; select_item = 2'd1;
    @(negedge clk); select_valid = 1'b0;
    restock_valid = 1'b1; restock_item = 2'd1; restock_qty = 4'd5;
    @(negedge clk); restock_valid = 1'b0;
    chk("dec+restock stock1", int'(dut.u_stock.stock_q[1]), 8);
    chk("dec+restock dispense_valid", int'(dispense_valid), 1);
    currency_avail = 1'b0; total_currency = '0;
    repeat (3) @(negedge clk);

    // reset while in CLEAR
    total_currency = 7'd10; currency_avail = 1'b1;
    @(negedge clk); select_valid = 1'b1; select_item = 2'd0;
    @(negedge clk); select_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset dispense_valid", int'(dispense_valid), 1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst dispense_valid", int'(dispense_valid), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst change_value", int'(change_value), 0);
    chk("midrst stock1", int'(dut.u_stock.stock_q[1]), 5);
    chk("midrst stock2", int'(dut.u_stock.stock_q[2]), 5);
    chk("midrst stock_empty", int'(stock_empty), 0);
    @(negedge clk);
    rstn = 1'b1; currency_avail = 1'b0; total_currency = '0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pulses += int'(vend_valid) + int'(change_valid) + int'(dispense_valid);
    end
    chk("post-reset pulses", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
